// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, reads instruction memory over a
// req/ack handshake and holds each fetched word until the downstream stage consumes it.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic        instr_valid,
    input  logic        consume,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_next;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic [15:0] pc_next, mem_addr_next, instr_next;
    logic        mem_req_next, instr_valid_next, fault_next;
    logic [15:0] pc_consumed;
    logic        timed_out;

    // pc + 1 wraps naturally in 16 bits
    assign pc_consumed = branch_en ? branch_target : pc + 16'd1;
    assign timed_out   = (wait_cnt + 8'd1) == TIMEOUT_CNT;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            pc          <= RESET_PC;
            mem_req     <= 1'b0;
            mem_addr    <= 16'h0000;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            pc          <= pc_next;
            mem_req     <= mem_req_next;
            mem_addr    <= mem_addr_next;
            instr       <= instr_next;
            instr_valid <= instr_valid_next;
            fault       <= fault_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!halt) state_next = REQ;
            REQ: begin
                if (mem_ack)        state_next = HOLD;
                else if (timed_out) state_next = FAULT;
            end
            HOLD:    if (consume) state_next = halt ? IDLE : REQ;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // A started fetch ignores halt; it only gates the start of the next one
    always_comb begin
        wait_cnt_next    = wait_cnt;
        pc_next          = pc;
        mem_req_next     = mem_req;
        mem_addr_next    = mem_addr;
        instr_next       = instr;
        instr_valid_next = instr_valid;
        fault_next       = fault;
        case (state)
            IDLE: begin
                if (!halt) begin
                    mem_req_next  = 1'b1;
                    mem_addr_next = pc;
                    wait_cnt_next = 8'd0;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    instr_next       = mem_rdata;
                    instr_valid_next = 1'b1;
                    mem_req_next     = 1'b0;
                    wait_cnt_next    = 8'd0;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                    if (timed_out) begin
                        mem_req_next = 1'b0;
                        fault_next   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (consume) begin
                    instr_valid_next = 1'b0;
                    pc_next          = pc_consumed;
                    if (!halt) begin
                        mem_req_next  = 1'b1;
                        mem_addr_next = pc_consumed;
                        wait_cnt_next = 8'd0;
                    end
                end
            end
            FAULT: begin
                mem_req_next     = 1'b0;
                instr_valid_next = 1'b0;
                fault_next       = 1'b1;
            end
            default: begin
                mem_req_next = 1'b0;
            end
        endcase
    end

endmodule
